adder_sequencer: RTL

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

---
 rtl/adder_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/adder_sequencer.sv
// adder_sequencer: sequences operands into an external ripple adder, waits SETTLE_CYCLES, captures the sum.
// Define ADDER_SEQ_OVERFLOW_EN to build the signed overflow flag; otherwise overflow is tied to 0.
module adder_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] add_x,
  output logic [31:0] add_y,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] add_x_q, add_x_d, add_y_q, add_y_d, result_q, result_d;
  logic        add_cin_q, add_cin_d, carry_q, carry_d;
  logic        capture;
  assign capture = (state_q == SETTLE) && (cnt_q == 4'd0);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    add_x_d   = add_x_q;
    add_y_d   = add_y_q;
    add_cin_d = add_cin_q;
    result_d  = result_q;
    carry_d   = carry_q;
    case (state_q)
      IDLE: if (in_valid) begin
        add_x_d   = a;
        add_y_d   = sub ? ~b : b;
        add_cin_d = sub;
        cnt_d     = CNT_INIT;
        state_d   = SETTLE;
      end
      SETTLE: if (capture) begin
        result_d = add_s;
        carry_d  = add_cout;
        state_d  = DONE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      add_x_q   <= 32'd0;
      add_y_q   <= 32'd0;
      add_cin_q <= 1'b0;
      result_q  <= 32'd0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_x_q   <= add_x_d;
      add_y_q   <= add_y_d;
      add_cin_q <= add_cin_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign add_cin   = add_cin_q;
  assign result    = result_q;
  assign carry     = carry_q;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic overflow_q, overflow_d;
  // Signed overflow: operands agree in sign but the sum's sign differs.
  always_comb overflow_d = capture ? (add_x_q[31] == add_y_q[31]) && (add_s[31] != add_x_q[31]) : overflow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif
endmodule
